// File: rtl/dma_cmd_queue.sv
// dma_cmd_queue: CPU command FIFO feeding the AHB-Lite master one command at a time.
// Commands are presented on NewCommandOn/o_dma_addr/o_buffer_length until Master_Done.
// Optional build macro: DMA_CMDQ_BACK2BACK_EN (chain the next command on Master_Done, skipping GAP).
module dma_cmd_queue #(
    parameter  int unsigned ADDR_W = 32,
    parameter  int unsigned LEN_W  = 6,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned PW     = $clog2(DEPTH),
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic              cmd_flush,
    input  logic              CoreSystemStart,
    input  logic              Master_Done,
    output logic              NewCommandOn,
    output logic [ADDR_W-1:0] o_dma_addr,
    output logic [LEN_W-1:0]  o_buffer_length,
    output logic [CW-1:0]     o_count,
    output logic              o_overflow,
    output logic              o_zero_len_err
);

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t            state_q, state_n;
    logic [CW-1:0]     count_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [LEN_W-1:0]  mem_len  [DEPTH];

    logic push, pop, has_cmd;

    assign wr_ready     = count_q < CW'(DEPTH);
    assign has_cmd      = count_q != '0;
    assign push         = wr_valid && wr_ready && (wr_len != '0) && !cmd_flush;
    assign NewCommandOn = state_q == ACTIVE;
    assign o_count      = count_q;

    // FSM state register
    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // Next-state and pop decision; flush blocks any issue in the same cycle
    always_comb begin
        state_n = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (has_cmd && CoreSystemStart && !cmd_flush) begin
                    pop     = 1'b1;
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                if (Master_Done) begin
`ifdef DMA_CMDQ_BACK2BACK_EN
                    if (has_cmd && CoreSystemStart && !cmd_flush) pop = 1'b1;
                    else                                          state_n = GAP;
`else
                    state_n = GAP;
`endif
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Queue pointers and occupancy; flush wins over push and pop
    always_ff @(posedge HCLK) begin
        if (HRESET || cmd_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
        end
    end

    // Entry storage; contents are only read behind valid pointers, so no reset
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= wr_addr;
            mem_len[wr_ptr_q]  <= wr_len;
        end
    end

    // Active command registers, loaded from the head on every pop
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            o_dma_addr      <= '0;
            o_buffer_length <= '0;
        end else if (pop) begin
            o_dma_addr      <= mem_addr[rd_ptr_q];
            o_buffer_length <= mem_len[rd_ptr_q];
        end
    end

    // Sticky error flags; a flush cycle discards the push without flagging it
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            o_overflow     <= 1'b0;
            o_zero_len_err <= 1'b0;
        end else if (!cmd_flush) begin
            if (wr_valid && !wr_ready)      o_overflow     <= 1'b1;
            if (wr_valid && wr_len == '0)   o_zero_len_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Self-checking bench for dma_cmd_queue: scoreboard of pushed commands compared at issue.
// Honours DMA_CMDQ_BACK2BACK_EN for the command-to-command sequence.
module tb_dma_cmd_queue;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [5:0]  wr_len;
    logic        cmd_flush;
    logic        CoreSystemStart;
    logic        Master_Done;
    logic        NewCommandOn;
    logic [31:0] o_dma_addr;
    logic [5:0]  o_buffer_length;
    logic [2:0]  o_count;
    logic        o_overflow;
    logic        o_zero_len_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [5:0]  len;
    } cmd_t;
    cmd_t        sb[$];
    logic [31:0] last_addr;

    always #5 HCLK = ~HCLK;

    dma_cmd_queue #(.ADDR_W(32), .LEN_W(6), .DEPTH(4)) dut (
        .HCLK            (HCLK),
        .HRESET          (HRESET),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_len          (wr_len),
        .cmd_flush       (cmd_flush),
        .CoreSystemStart (CoreSystemStart),
        .Master_Done     (Master_Done),
        .NewCommandOn    (NewCommandOn),
        .o_dma_addr      (o_dma_addr),
        .o_buffer_length (o_buffer_length),
        .o_count         (o_count),
        .o_overflow      (o_overflow),
        .o_zero_len_err  (o_zero_len_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; inputs change and outputs are sampled 1ns later
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [5:0] l, input bit exp_acc);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_len   = l;
        step();
        wr_valid = 1'b0;
        if (exp_acc) sb.push_back('{addr: a, len: l});
    endtask

    task automatic wait_issue(input string tag);
        int unsigned n = 0;
        while (NewCommandOn !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_issue"}, 64'(NewCommandOn), 64'd1);
    endtask

    task automatic cmp_head(input string tag);
        cmd_t c;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            c = sb.pop_front();
            last_addr = c.addr;
            chk({tag, "_addr"}, 64'(o_dma_addr), 64'(c.addr));
            chk({tag, "_len"},  64'(o_buffer_length), 64'(c.len));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_nco"},   64'(NewCommandOn), 64'd0);
        chk({tag, "_addr"},  64'(o_dma_addr), 64'd0);
        chk({tag, "_len"},   64'(o_buffer_length), 64'd0);
        chk({tag, "_cnt"},   64'(o_count), 64'd0);
        chk({tag, "_ovf"},   64'(o_overflow), 64'd0);
        chk({tag, "_zle"},   64'(o_zero_len_err), 64'd0);
        chk({tag, "_ready"}, 64'(wr_ready), 64'd1);
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_len = '0;
        cmd_flush = 1'b0; CoreSystemStart = 1'b0; Master_Done = 1'b0;
        step();
        do_reset();
        check_reset_values("rst");

        // Single command: issue exactly one cycle after the push edge
        CoreSystemStart = 1'b1;
        push(32'h1000_0040, 6'd8, 1'b1);
        chk("t1_cnt_push", 64'(o_count), 64'd1);
        chk("t1_nco_push", 64'(NewCommandOn), 64'd0);
        step();
        chk("t1_nco_issue", 64'(NewCommandOn), 64'd1);
        chk("t1_cnt_issue", 64'(o_count), 64'd0);
        cmp_head("t1");
        Master_Done = 1'b1; step(); Master_Done = 1'b0;
        chk("t1_nco_done", 64'(NewCommandOn), 64'd0);
        chk("t1_addr_kept", 64'(o_dma_addr), 64'h1000_0040);
        step();

        // Fill while stalled, overflow on the fifth, then in-order drain
        CoreSystemStart = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'hA000_0000 + 32'(i) * 32'h100, 6'(i + 1), 1'b1);
        chk("t2_ready_full", 64'(wr_ready), 64'd0);
        chk("t2_cnt_full", 64'(o_count), 64'd4);
        push(32'hDEAD_BEEF, 6'd9, 1'b0);
        chk("t2_ovf", 64'(o_overflow), 64'd1);
        chk("t2_cnt_after_ovf", 64'(o_count), 64'd4);
        CoreSystemStart = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_issue("t2_ord");
            cmp_head("t2_ord");
            chk("t2_ord_cnt", 64'(o_count), 64'(3 - i));
            Master_Done = 1'b1; step(); Master_Done = 1'b0;
            if (i < 3) begin
`ifdef DMA_CMDQ_BACK2BACK_EN
                chk("t2_b2b_hold", 64'(NewCommandOn), 64'd1);
`else
                chk("t2_gap_low", 64'(NewCommandOn), 64'd0);
                step();
                chk("t2_idle_low", 64'(NewCommandOn), 64'd0);
                step();
                chk("t2_m2_issue", 64'(NewCommandOn), 64'd1);
`endif
            end else begin
                chk("t2_last_done", 64'(NewCommandOn), 64'd0);
            end
        end
        step();

        // Zero-length push is dropped and flagged
        push(32'h2222_0000, 6'd0, 1'b0);
        chk("t3_zle", 64'(o_zero_len_err), 64'd1);
        chk("t3_cnt", 64'(o_count), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_no_issue", 64'(NewCommandOn), 64'd0);
        end

        // Flush with a same-cycle push into a full queue while a command is active
        do_reset();
        chk("t4_flags_clear_ovf", 64'(o_overflow), 64'd0);
        chk("t4_flags_clear_zle", 64'(o_zero_len_err), 64'd0);
        CoreSystemStart = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'hB000_0000 + 32'(i) * 32'h40, 6'(10 + i), 1'b1);
        CoreSystemStart = 1'b1;
        wait_issue("t4");
        cmp_head("t4");
        CoreSystemStart = 1'b0;
        push(32'hB000_1000, 6'd20, 1'b1);
        chk("t4_cnt_refill", 64'(o_count), 64'd4);
        cmd_flush = 1'b1;
        push(32'hB000_2000, 6'd21, 1'b0);
        cmd_flush = 1'b0;
        sb.delete();
        chk("t4_cnt_flushed", 64'(o_count), 64'd0);
        chk("t4_nco_kept", 64'(NewCommandOn), 64'd1);
        chk("t4_addr_kept", 64'(o_dma_addr), 64'(last_addr));
        chk("t4_no_ovf", 64'(o_overflow), 64'd0);
        chk("t4_no_zle", 64'(o_zero_len_err), 64'd0);
        CoreSystemStart = 1'b1;
        Master_Done = 1'b1; step(); Master_Done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_nothing_left", 64'(NewCommandOn), 64'd0);
        end

        // Reset while active with two queued, then normal operation resumes
        CoreSystemStart = 1'b0;
        for (int i = 0; i < 3; i++)
            push(32'hC000_0000 + 32'(i) * 32'h8, 6'(30 + i), 1'b1);
        CoreSystemStart = 1'b1;
        wait_issue("t5");
        cmp_head("t5");
        chk("t5_cnt", 64'(o_count), 64'd2);
        do_reset();
        check_reset_values("t5_rst");
        step();
        chk("t5_no_issue_after_rst", 64'(NewCommandOn), 64'd0);
        push(32'h3000_0100, 6'd63, 1'b1);
        wait_issue("t5_post");
        cmp_head("t5_post");
        Master_Done = 1'b1; step(); Master_Done = 1'b0;
        chk("t5_post_done", 64'(NewCommandOn), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
